// File: rtl/mealy_fsm_prog.sv
// ---------------------------------------------------------------------------
// mealy_fsm_prog
//   Runtime-programmable Mealy machine. Each transition/output entry
//   {next, out} is indexed by (current state, input symbol) and is written
//   through a config port. One transition is taken per cycle while ctrl_in is
//   high. The state register and the output register update together.
//
// Parameters
//   NUM_STATES : number of legal states (2..16)
//   IN_W       : input symbol width; the table has NUM_STATES * 2^IN_W entries
//   OUT_W      : output word width per transition
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   cfg_we     : table write strobe
//   cfg_state  : table row to write
//   cfg_sym    : table column to write
//   cfg_next   : next-state value for the entry
//   cfg_out    : output value for the entry
//   init_load  : load state from state_in (takes priority over ctrl_in)
//   state_in   : initial/forced state
//   sw_in      : current input symbol
//   ctrl_in    : step enable
//   err_clr    : clears the sticky err flag
//   state      : current state (registered)
//   out        : output of the last transition taken (registered)
//   err        : sticky error flag (illegal write or illegal load)
//   step_cnt   : steps taken since reset/last load (only with MEALY_STEP_CNT_EN)
//
// Optional feature macro: MEALY_STEP_CNT_EN
// ---------------------------------------------------------------------------
module mealy_fsm_prog #(
  parameter int NUM_STATES = 3,
  parameter int IN_W       = 2,
  parameter int OUT_W      = 1,
  localparam int ST_W      = (NUM_STATES > 2) ? $clog2(NUM_STATES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [ST_W-1:0]   cfg_state,
  input  logic [IN_W-1:0]   cfg_sym,
  input  logic [ST_W-1:0]   cfg_next,
  input  logic [OUT_W-1:0]  cfg_out,
  input  logic              init_load,
  input  logic [ST_W-1:0]   state_in,
  input  logic [IN_W-1:0]   sw_in,
  input  logic              ctrl_in,
  input  logic              err_clr,
`ifdef MEALY_STEP_CNT_EN
  output logic [15:0]       step_cnt,
`endif
  output logic [ST_W-1:0]   state,
  output logic [OUT_W-1:0]  out,
  output logic              err
);

  localparam int NUM_SYM = 1 << IN_W;
  // One extra bit so NUM_STATES itself is representable for range checks.
  localparam logic [ST_W:0] NS_L = (ST_W+1)'(NUM_STATES);

  logic [ST_W-1:0]  tbl_next_r [NUM_STATES][NUM_SYM];
  logic [OUT_W-1:0] tbl_out_r  [NUM_STATES][NUM_SYM];

  logic [ST_W-1:0]  state_r;
  logic [OUT_W-1:0] out_r;
  logic             err_r;

  logic [ST_W-1:0]  state_nxt_s;
  logic [OUT_W-1:0] out_nxt_s;
  logic             err_nxt_s;
  logic             wr_ok_s;
  logic             wr_bad_s;
  logic             ld_ok_s;
  logic             ld_bad_s;
  logic             step_s;
  logic [ST_W-1:0]  rd_next_s;
  logic [OUT_W-1:0] rd_out_s;

`ifdef MEALY_STEP_CNT_EN
  logic [15:0]      cnt_r;
  logic [15:0]      cnt_nxt_s;
`endif

  // Table storage: reset to "hold" (next = own row, out = 0), legal writes commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        for (int j = 0; j < NUM_SYM; j++) begin
          tbl_next_r[i][j] <= ST_W'(i);
          tbl_out_r[i][j]  <= {OUT_W{1'b0}};
        end
      end
    end else begin
      if (wr_ok_s) begin
        tbl_next_r[cfg_state][cfg_sym] <= cfg_next;
        tbl_out_r[cfg_state][cfg_sym]  <= cfg_out;
      end else begin
        tbl_next_r[state_r][sw_in] <= tbl_next_r[state_r][sw_in];
      end
    end
  end

  // State, output and error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= {ST_W{1'b0}};
      out_r   <= {OUT_W{1'b0}};
      err_r   <= 1'b0;
`ifdef MEALY_STEP_CNT_EN
      cnt_r   <= 16'd0;
`endif
    end else begin
      state_r <= state_nxt_s;
      out_r   <= out_nxt_s;
      err_r   <= err_nxt_s;
`ifdef MEALY_STEP_CNT_EN
      cnt_r   <= cnt_nxt_s;
`endif
    end
  end

  // Next-state logic: table read uses the pre-write contents, so a same-edge
  // write to the entry being read only affects the following step.
  always_comb begin
    rd_next_s   = tbl_next_r[state_r][sw_in];
    rd_out_s    = tbl_out_r[state_r][sw_in];
    wr_ok_s     = 1'b0;
    wr_bad_s    = 1'b0;
    ld_ok_s     = 1'b0;
    ld_bad_s    = 1'b0;
    step_s      = 1'b0;
    state_nxt_s = state_r;
    out_nxt_s   = out_r;
    err_nxt_s   = err_r;

    if (cfg_we) begin
      if (({1'b0, cfg_state} < NS_L) && ({1'b0, cfg_next} < NS_L)) begin
        wr_ok_s = 1'b1;
      end else begin
        wr_bad_s = 1'b1;
      end
    end else begin
      wr_ok_s = 1'b0;
    end

    if (init_load) begin
      if ({1'b0, state_in} < NS_L) begin
        ld_ok_s     = 1'b1;
        state_nxt_s = state_in;
      end else begin
        ld_bad_s = 1'b1;
      end
    end else if (ctrl_in) begin
      step_s      = 1'b1;
      state_nxt_s = rd_next_s;
      out_nxt_s   = rd_out_s;
    end else begin
      state_nxt_s = state_r;
    end

    // A new error on the same edge as err_clr wins.
    if (wr_bad_s || ld_bad_s) begin
      err_nxt_s = 1'b1;
    end else if (err_clr) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = err_r;
    end
  end

`ifdef MEALY_STEP_CNT_EN
  // Step counter next value: cleared by a successful load, wraps naturally.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (ld_ok_s) begin
      cnt_nxt_s = 16'd0;
    end else if (step_s) begin
      cnt_nxt_s = cnt_r + 16'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end
`endif

  // Output drive straight from the registers.
  always_comb begin
    state = state_r;
    out   = out_r;
    err   = err_r;
`ifdef MEALY_STEP_CNT_EN
    step_cnt = cnt_r;
`endif
  end

endmodule

// File: doc/mealy_fsm_prog.md
Name: mealy_fsm_prog

Overview:
Runtime-programmable Mealy machine with a parametrised state count, input-symbol width and output width.
The transition/output table is written through a config port instead of being hard-coded, so one instance can run any small FSM.
Sits between switch/config front-end logic and output drivers.
Steps one transition per cycle when the step strobe is high; the output is registered with the state.

Parameters:
NUM_STATES, 3, number of legal states (2..16); ST_W = max(1, $clog2(NUM_STATES))
IN_W, 2, input symbol width; table has NUM_STATES*2^IN_W entries
OUT_W, 1, output word width per transition

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
cfg_we  input  1  table write strobe
cfg_state  input  ST_W  table row (current state) to write
cfg_sym  input  IN_W  table column (input symbol) to write
cfg_next  input  ST_W  next-state value for the entry
cfg_out  input  OUT_W  output value for the entry
init_load  input  1  load state from state_in
state_in  input  ST_W  initial/forced state
sw_in  input  IN_W  current input symbol
ctrl_in  input  1  step enable: take one transition this cycle
err_clr  input  1  clears sticky err
state  output  ST_W  current state (registered)
out  output  OUT_W  output of last transition taken (registered)
err  output  1  sticky error flag

Behaviour:
- Reset (reset=0, async): state=0, out=0, err=0.
- Reset also clears every table entry to "hold": next = own row, out = 0.
- Table: NUM_STATES x 2^IN_W entries of {next, out}, held in flops; read combinationally at (state, sw_in).
- Write: on a clk edge with cfg_we=1, entry[cfg_state][cfg_sym] <= {cfg_next, cfg_out}.
- Write rejected (table unchanged, err<=1) if cfg_state >= NUM_STATES or cfg_next >= NUM_STATES.
- Per-edge priority: init_load > ctrl_in.
  - init_load=1, state_in < NUM_STATES: state <= state_in, out unchanged.
  - init_load=1, state_in out of range: state unchanged, err <= 1.
  - init_load=0, ctrl_in=1: state <= entry.next, out <= entry.out, both from the table value before any same-edge write.
  - Neither asserted: state and out hold.
- Write and step on the same edge:
  - The write always commits if legal.
  - A write to the entry currently being read affects only the next step (read-before-write).
- Latency: sw_in sampled on the stepping edge; state/out visible one cycle after ctrl_in.
- err:
  - Sticky; cleared by err_clr=1 on an edge unless a new error occurs on that same edge (set wins).
  - Cleared by reset.
- State register can never hold a value >= NUM_STATES: both load paths and the table contents are range-checked.
- Reset asserted mid-operation: immediate async clear of state, out, err and the table; no partial write survives.

Optional Feature:
Macro MEALY_STEP_CNT_EN.
- When defined:
  - Adds output step_cnt [15:0], reset 0.
  - Increments on every edge where a step is taken (ctrl_in=1 and init_load=0); wraps 0xFFFF -> 0.
  - Cleared to 0 on an edge with a successful init_load.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset with defaults, then ctrl_in=1 with sw_in=0..3 → state=0, out=0 every cycle (hold table).
- Program row0 {0:1/1, 1:2/0, 2:1/1, 3:0/0}, row1 {0..2:2/1, 3:0/0}, row2 {0:0/1, 1:0/1, 2:2/0, 3:0/0}.
  - Step sw_in 0,1,2,3 from state 0 → state 1,2,2,0; out 1,1,0,0.
- cfg_we writing row0 col0 := 2/0 on the same edge as a step from state0 with sw_in=0 → state=1, out=1; next step from state0/sw0 → state=2, out=0.
- cfg_next=3 with NUM_STATES=3 → table unchanged, err=1.
  - err_clr pulse → err=0.
  - init_load with state_in=3 → state held, err=1.
- init_load=1 and ctrl_in=1 together with state_in=2 → state=2, out unchanged.
- With MEALY_STEP_CNT_EN: 5 steps → step_cnt=5; init_load → 0.
- Reset pulled low mid-sequence → state/out/err/step_cnt = 0 asynchronously; table reverts to hold.
